line_fetch: RTL and testbench
=============================

LINE_FETCH -- requirements
Module: line_fetch

Interface
REQ-001 Parameter CORDW, 16, signed coordinate width; matches the display controller.
REQ-002 Parameter ADDRW, 16, framebuffer word-address width.
REQ-003 Parameter WORDS, 80, memory words per display line (range 2..2^ADDRW-1).
REQ-004 clk_pix  in  1  pixel clock; sole clock of the block.
REQ-005 rst_pix_n  in  1  reset, asynchronous assert, active-low.
REQ-006 frame_start, line_start  in  1 each  single-cycle strobes from the display controller.
REQ-007 dy  in  CORDW signed  display line, aligned with line_start; vres  in  CORDW signed  vertical resolution.
REQ-008 enable  in  1  fetch enable; fb_base  in  ADDRW  framebuffer start word address.
REQ-009 mem_req  out  1, mem_addr  out  ADDRW, mem_ack  in  1: request/acknowledge handshake, one word per ack.
REQ-010 lb_wsel  out  1  line-buffer half being written; lb_rsel  out  1  half being displayed (always ~lb_wsel).
REQ-011 busy  out  1  fetch in progress; underrun  out  1  single-cycle pulse on aborted fetch; underrun_cnt  out  16  saturating count.

Function
REQ-012 The fetch window is -1 <= dy <= vres-2; the line fetched during line dy is line dy+1.
REQ-013 States: IDLE, FETCH; busy SHALL be 1 exactly in FETCH.
REQ-014 frame_start SHALL load line_base <= fb_base, sampled only at that cycle.
REQ-015 IDLE->FETCH on line_start with enable=1 and dy in window: cur_addr <= line_base, line_base <= line_base+WORDS, count <= 0, lb_wsel toggles.
REQ-016 If frame_start and a qualifying line_start coincide, the fetch SHALL use fb_base and line_base SHALL become fb_base+WORDS.
REQ-017 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal cur_addr; both are registered outputs, first valid the cycle after entry.
REQ-018 mem_req and mem_addr SHALL hold stable until mem_ack; mem_ack outside FETCH SHALL be ignored.
REQ-019 On mem_ack: cur_addr +1, count +1; on the ack with count==WORDS-1, the block SHALL go to IDLE and drop mem_req in the next cycle.
REQ-020 A line_start while in FETCH SHALL pulse underrun for 1 cycle, abandon the fetch, and re-evaluate REQ-015 in the same cycle.
REQ-021 A mem_ack coinciding with an aborting line_start SHALL be counted as lost; no address carry-over.
REQ-022 Address arithmetic SHALL wrap modulo 2^ADDRW.
REQ-023 enable deasserted mid-FETCH SHALL NOT abort the current line; new fetches are suppressed.
REQ-024 Lines outside the window SHALL leave line_base and lb_wsel unchanged.

Reset
REQ-025 While rst_pix_n=0: state IDLE, mem_req 0, mem_addr 0, lb_wsel 0, lb_rsel 1, busy 0, underrun 0, underrun_cnt 0, line_base 0.
REQ-026 Reset asserted mid-FETCH SHALL drop mem_req asynchronously; no request resumes after release.
REQ-027 After release, no fetch begins before the next qualifying line_start.

Configuration
REQ-028 Macro LINE_FETCH_STATS_EN defined: underrun_cnt increments on each underrun pulse, saturates at 16'hFFFF, and is cleared only by reset.
REQ-029 Macro LINE_FETCH_STATS_EN undefined: underrun_cnt is constant 0 and no counter logic is generated; underrun is unaffected.

Structure
REQ-030 The FETCH/IDLE state encoding and the default WORDS value SHALL be placed in the shared gfx package.
REQ-031 The block is a single module; no sub-module.

Verification (WORDS=4, vres=3, fb_base=16'h1000 unless stated)
REQ-032 frame_start, then line_start at dy=-1 with ack every cycle -> mem_addr 1000,1001,1002,1003, lb_wsel 0->1, busy for 4 acked cycles.
REQ-033 line_start at dy=0,1 -> fetches at 1004 and 1008; dy=2 -> no fetch and lb_wsel unchanged.
REQ-034 No ack, next line_start -> underrun pulse, underrun_cnt=1 (with STATS_EN), new fetch starts at the next line base.
REQ-035 fb_base=16'hFFFE -> addresses FFFE, FFFF, 0000, 0001.
REQ-036 rst_pix_n low mid-FETCH -> mem_req 0 immediately; all outputs at reset values; idle until the next qualifying line_start.
REQ-037 frame_start coincident with line_start at dy=-1 (v_sta=-1) -> fetch at fb_base; the following line at fb_base+4.

Source files
------------

// File: rtl/line_fetch_pkg.sv
// Shared definitions for the line fetcher: state encoding and default line length.
package line_fetch_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

    localparam int unsigned WORDS_DEF = 80;

endpackage

// File: rtl/line_fetch_if.sv
// Framebuffer read-request bus: one word address per request, one word per ack.
interface line_fetch_if #(
    parameter int ADDRW = 16
);
    logic             mem_req;
    logic [ADDRW-1:0] mem_addr;
    logic             mem_ack;

    modport master (output mem_req, output mem_addr, input mem_ack);
    modport slave  (input mem_req, input mem_addr, output mem_ack);
endinterface

// File: rtl/line_fetch.sv
// Fetches the next display line from the framebuffer into a ping-pong line buffer.
// Optional underrun statistics counter enabled by `define LINE_FETCH_STATS_EN.
module line_fetch
    import line_fetch_pkg::*;
#(
    parameter int CORDW = 16,
    parameter int ADDRW = 16,
    parameter int WORDS = WORDS_DEF
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix_n,
    input  logic                    frame_start,
    input  logic                    line_start,
    input  logic signed [CORDW-1:0] dy,
    input  logic signed [CORDW-1:0] vres,
    input  logic                    enable,
    input  logic        [ADDRW-1:0] fb_base,
    line_fetch_if.master            mem,
    output logic                    lb_wsel,
    output logic                    lb_rsel,
    output logic                    busy,
    output logic                    underrun,
    output logic        [15:0]      underrun_cnt
);

    localparam logic signed [CORDW:0] MINUS1 = '1;
    localparam logic [ADDRW-1:0]      LAST   = ADDRW'(WORDS - 1);
    localparam logic [ADDRW-1:0]      STRIDE = ADDRW'(WORDS);

    fetch_state_t state, state_nxt;

    logic [ADDRW-1:0]       line_base;
    logic [ADDRW-1:0]       cur_addr;
    logic [ADDRW-1:0]       count;
    logic signed [CORDW:0]  dy_ext;
    logic signed [CORDW:0]  win_hi;
    logic                   in_window;
    logic                   start;
    logic                   abort;
    logic                   ack_ok;
    logic [ADDRW-1:0]       base_eff;

    // Widened by one bit so vres-2 cannot overflow at the extremes.
    assign dy_ext    = {dy[CORDW-1], dy};
    assign win_hi    = {vres[CORDW-1], vres} - (CORDW+1)'(2);
    assign in_window = (dy_ext >= MINUS1) && (dy_ext <= win_hi);

    assign start    = line_start && enable && in_window;
    assign abort    = (state == FETCH) && line_start;
    assign ack_ok   = (state == FETCH) && mem.mem_ack && !line_start;
    assign base_eff = frame_start ? fb_base : line_base;

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = FETCH;
            FETCH: begin
                if (line_start) begin
                    state_nxt = start ? FETCH : IDLE;
                end else if (mem.mem_ack && count == LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == FETCH);
        mem.mem_req = (state == FETCH);
    end

    assign mem.mem_addr = cur_addr;
    assign lb_rsel      = ~lb_wsel;

    // A new qualifying line_start takes priority over any ack in the same cycle.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            line_base <= '0;
            cur_addr  <= '0;
            count     <= '0;
            lb_wsel   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= abort;
            if (frame_start) begin
                line_base <= fb_base;
            end
            if (start) begin
                cur_addr  <= base_eff;
                line_base <= base_eff + STRIDE;
                count     <= '0;
                lb_wsel   <= ~lb_wsel;
            end else if (ack_ok) begin
                cur_addr <= cur_addr + ADDRW'(1);
                count    <= count + ADDRW'(1);
            end
        end
    end

`ifdef LINE_FETCH_STATS_EN
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            underrun_cnt <= '0;
        end else if (abort && underrun_cnt != '1) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_line_fetch.sv
// Randomised self-checking bench for line_fetch against a line-level reference model.
module tb_line_fetch;

    localparam int WORDS = 4;

    logic               clk_pix = 1'b0;
    logic               rst_pix_n;
    logic               frame_start;
    logic               line_start;
    logic signed [15:0] dy;
    logic signed [15:0] vres;
    logic               enable;
    logic        [15:0] fb_base;
    logic               lb_wsel;
    logic               lb_rsel;
    logic               busy;
    logic               underrun;
    logic        [15:0] underrun_cnt;

    line_fetch_if #(.ADDRW(16)) mem_bus ();

    line_fetch #(
        .CORDW(16),
        .ADDRW(16),
        .WORDS(WORDS)
    ) dut (
        .clk_pix      (clk_pix),
        .rst_pix_n    (rst_pix_n),
        .frame_start  (frame_start),
        .line_start   (line_start),
        .dy           (dy),
        .vres         (vres),
        .enable       (enable),
        .fb_base      (fb_base),
        .mem          (mem_bus),
        .lb_wsel      (lb_wsel),
        .lb_rsel      (lb_rsel),
        .busy         (busy),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk_pix = ~clk_pix;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: one line = WORDS consecutive addresses from the current line base.
    bit          m_busy;
    bit   [15:0] m_addr;
    int          m_left;
    bit   [15:0] m_base;
    bit          m_wsel;
    bit          m_urun;
    int          m_ucnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_addr = '0; m_left = 0; m_base = '0;
        m_wsel = 0; m_urun = 0; m_ucnt = 0;
    endtask

    task automatic check_model();
        check("busy", busy, m_busy);
        check("mem_req", mem_bus.mem_req, m_busy);
        if (m_busy) check("mem_addr", mem_bus.mem_addr, m_addr);
        check("lb_wsel", lb_wsel, m_wsel);
        check("lb_rsel", lb_rsel, !m_wsel);
        check("underrun", underrun, m_urun);
`ifdef LINE_FETCH_STATS_EN
        check("underrun_cnt", underrun_cnt, m_ucnt);
`else
        check("underrun_cnt", underrun_cnt, 0);
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the clock edge, then compare.
    task automatic cycle(input bit fs, input bit ls, input int dyv, input bit ack);
        bit   was_busy;
        bit   win;
        bit [15:0] base;
        frame_start     = fs;
        line_start      = ls;
        dy              = 16'(dyv);
        mem_bus.mem_ack = ack;
        @(posedge clk_pix);
        was_busy = m_busy;
        win  = ls && enable && (dyv >= -1) && (dyv <= int'(vres) - 2);
        base = fs ? fb_base : m_base;
        m_urun = was_busy && ls;
        if (m_urun && m_ucnt < 65535) m_ucnt++;
        if (fs) m_base = fb_base;
        if (win) begin
            m_busy = 1; m_addr = base; m_left = WORDS;
            m_base = base + 16'(WORDS); m_wsel = !m_wsel;
        end else if (ls && was_busy) begin
            m_busy = 0;
        end else if (was_busy && ack) begin
            m_addr = m_addr + 16'd1;
            m_left--;
            if (m_left == 0) m_busy = 0;
        end
        #1;
        check_model();
    endtask

    initial begin
        rst_pix_n = 1'b0; frame_start = 0; line_start = 0; dy = '0;
        vres = 16'sd3; enable = 1'b1; fb_base = 16'h1000; mem_bus.mem_ack = 0;
        model_reset();
        repeat (2) @(posedge clk_pix);
        #1;
        check_model();
        check("rst_addr", mem_bus.mem_addr, 16'h0000);
        rst_pix_n = 1'b1;

        // First line fetched at fb_base with ack every cycle.
        cycle(1, 0, 0, 0);
        cycle(0, 1, -1, 0);
        check("l0_addr0", mem_bus.mem_addr, 16'h1000);
        check("l0_wsel", lb_wsel, 1'b1);
        for (int i = 1; i < 4; i++) begin
            cycle(0, 0, 0, 1);
            check("l0_addr", mem_bus.mem_addr, 32'h1000 + i);
        end
        cycle(0, 0, 0, 1);
        check("l0_done", busy, 1'b0);
        cycle(0, 0, 0, 1);

        // Following lines advance by WORDS; the last window line fetches nothing.
        cycle(0, 1, 0, 0);
        check("l1_addr", mem_bus.mem_addr, 16'h1004);
        repeat (4) cycle(0, 0, 0, 1);
        cycle(0, 1, 1, 0);
        check("l2_addr", mem_bus.mem_addr, 16'h1008);
        repeat (4) cycle(0, 0, 0, 1);
        cycle(0, 1, 2, 0);
        check("l3_nofetch", busy, 1'b0);
        check("l3_wsel", lb_wsel, 1'b1);

        // Unacked fetch aborted by the next line_start.
        cycle(0, 1, -1, 0);
        check("ur_first", mem_bus.mem_addr, 16'h100C);
        repeat (3) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 1);
        check("ur_pulse", underrun, 1'b1);
        check("ur_newaddr", mem_bus.mem_addr, 16'h1010);
        cycle(0, 0, 0, 0);
        check("ur_oneshot", underrun, 1'b0);
        repeat (4) cycle(0, 0, 0, 1);

        // frame_start coincident with a qualifying line_start.
        fb_base = 16'h2000;
        cycle(1, 1, -1, 1);
        check("co_addr", mem_bus.mem_addr, 16'h2000);
        repeat (4) cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0);
        check("co_next", mem_bus.mem_addr, 16'h2004);
        repeat (4) cycle(0, 0, 0, 1);

        // Address wrap across the top of the address space.
        fb_base = 16'hFFFE;
        cycle(1, 1, -1, 0);
        check("wr_0", mem_bus.mem_addr, 16'hFFFE);
        cycle(0, 0, 0, 1);
        check("wr_1", mem_bus.mem_addr, 16'hFFFF);
        cycle(0, 0, 0, 1);
        check("wr_2", mem_bus.mem_addr, 16'h0000);
        cycle(0, 0, 0, 1);
        check("wr_3", mem_bus.mem_addr, 16'h0001);

        // Asynchronous reset mid-fetch.
        rst_pix_n = 1'b0;
        #1;
        check("ar_req", mem_bus.mem_req, 1'b0);
        check("ar_busy", busy, 1'b0);
        check("ar_wsel", lb_wsel, 1'b0);
        check("ar_rsel", lb_rsel, 1'b1);
        check("ar_addr", mem_bus.mem_addr, 16'h0000);
        check("ar_cnt", underrun_cnt, 16'h0000);
        model_reset();
        @(negedge clk_pix);
        rst_pix_n = 1'b1;
        @(posedge clk_pix);
        #1;
        repeat (5) cycle(0, 0, 0, 1);
        check("ar_idle", mem_bus.mem_req, 1'b0);

        // Randomised traffic.
        fb_base = 16'h3000;
        cycle(1, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            bit fs, ls, ack;
            int dyv;
            if ($urandom_range(0, 199) == 0) fb_base = 16'($urandom);
            if ($urandom_range(0, 49) == 0) enable = !enable;
            if ($urandom_range(0, 39) == 0) vres = 16'($urandom_range(0, 6));
            fs  = ($urandom_range(0, 29) == 0);
            ls  = ($urandom_range(0, 5) == 0);
            dyv = int'($urandom_range(0, 8)) - 3;
            ack = ($urandom_range(0, 9) < 7);
            cycle(fs, ls, dyv, ack);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
